xyz_unpacker: RTL and testbench
===============================

XYZ_UNPACKER -- requirements
Module: xyz_unpacker

Interface
REQ-001 Parameter SKIP_ZERO, default 0: when 1, fields X, Y and Z with value zero are not emitted; W is always emitted.
REQ-002 Parameter DEPTH, default 2: input buffer entries; the legal values are 2 and 4.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the word on in_data is valid.
REQ-006 Port in_ready, output, 1: the block accepts a word this cycle.
REQ-007 Port in_data, input, 8: packed xyz_t word with x in bit 7, y in bits 6:3, z in bit 2 and w in bits 1:0.
REQ-008 Port field_valid, output, 1: a field is presented.
REQ-009 Port field_ready, input, 1: the consumer accepts the field.
REQ-010 Port field_id, output, 2: field code, X=0, Y=1, Z=2, W=3.
REQ-011 Port field_data, output, 4: field value, zero-extended (x and z in bit 0, w in bits 1:0).
REQ-012 Port field_last, output, 1: set on the final field of a word.

Function
REQ-013 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge; the word is written to the buffer tail.
REQ-014 in_ready = 1 exactly when the buffer is not full; it does not depend combinationally on field_ready.
REQ-015 An output transfer occurs when field_valid and field_ready are both 1 on a rising edge.
REQ-016 The FSM has the states IDLE, EMIT_X, EMIT_Y, EMIT_Z and EMIT_W; it holds the current word in a register popped from the buffer head.
REQ-017 IDLE with the buffer non-empty: pop the head and go to the first field to emit; otherwise stay in IDLE.
REQ-018 Field order is X, Y, Z, W; the FSM advances only on an output transfer, and with SKIP_ZERO=1 it jumps past zero-valued X, Y and Z.
REQ-019 EMIT_W on transfer with the buffer non-empty: pop the next word and go straight to its first field, with no bubble; otherwise go to IDLE.
REQ-020 Latency: a word accepted at edge N into an empty IDLE block shows its first field at cycle N+1.
REQ-021 Throughput with SKIP_ZERO=0 is 4 cycles per word; with SKIP_ZERO=1 and an all-zero word it is 1 cycle per word.
REQ-022 field_id, field_data and field_last are registered and do not change while field_valid=1 and field_ready=0.
REQ-023 field_last = 1 only in EMIT_W.
REQ-024 Push and pop in the same cycle on a full buffer is legal only when a pop occurs, and in_ready already reflects full; occupancy is unchanged and no word is lost or duplicated.
REQ-025 Buffer pointers wrap modulo DEPTH; full and empty are decided by an occupancy counter of width clog2(DEPTH)+1.
REQ-026 Words are emitted in acceptance order.

Reset
REQ-027 rst asserted: FSM=IDLE, occupancy=0, pointers=0, field_valid=0, field_id=0, field_data=0, field_last=0, and in_ready=0 while rst=1.
REQ-028 Reset during emission discards the current word and all buffered words, and no partial field follows reset release.
REQ-029 in_ready rises on the first rising edge after rst is deasserted.

Structure
REQ-030 Package xyz_pkg holds the xyz_t packed struct (x, y[3:0], z, w[1:0]), the field_id_e enum, and the XYZ_W=8 constant.
REQ-031 The buffer is the sub-module xyz_fifo (parameter DEPTH, push/pop/full/empty); the FSM and the output register stay in xyz_unpacker.

Verification
REQ-032 SKIP_ZERO=0, in_data=8'hD3, field_ready=1 -> (0,1), (1,4'hA), (2,0), (3,3,last) on four consecutive cycles, starting one cycle after acceptance.
REQ-033 SKIP_ZERO=1, in_data=8'h00 then 8'h84 -> (3,0,last); then (0,1), (2,1), (3,0,last), and Y is skipped.
REQ-034 DEPTH=2, 3 words sent back-to-back, field_ready=0 -> in_ready=0 after 3 accepted (one in the FSM register, two in the buffer); release field_ready -> all 12 fields in order with no bubbles.
REQ-035 field_ready toggling 1/0 each cycle -> each field is held stable while stalled, and no field is repeated or dropped.
REQ-036 rst pulsed while emitting Y of 8'hFF with one word buffered -> outputs at reset values; after release and a new word 8'h01, only that word's fields appear.

Source files
------------

// File: rtl/xyz_pkg.sv
// Shared types for the xyz word unpacker.
// Word layout, field codes and field selection helpers.
package xyz_pkg;

   localparam int XYZ_W = 8;

   typedef struct packed {
      logic       x;
      logic [3:0] y;
      logic       z;
      logic [1:0] w;
   } xyz_t;

   typedef enum logic [1:0] {
      FLD_X = 2'd0,
      FLD_Y = 2'd1,
      FLD_Z = 2'd2,
      FLD_W = 2'd3
   } field_id_e;

   // First field at or after 'from' that is emitted; W is never skipped.
   function automatic field_id_e next_field(
      input xyz_t       wd,
      input logic [1:0] from,
      input logic       skip
   );
      field_id_e f;
      f = FLD_W;
      if (from <= 2'd2 && !(skip && !wd.z))
         f = FLD_Z;
      if (from <= 2'd1 && !(skip && wd.y == 4'd0))
         f = FLD_Y;
      if (from == 2'd0 && !(skip && !wd.x))
         f = FLD_X;
      return f;
   endfunction

   function automatic logic [3:0] field_val(
      input xyz_t      wd,
      input field_id_e f
   );
      logic [3:0] v;
      unique case (f)
         FLD_X:   v = {3'b000, wd.x};
         FLD_Y:   v = wd.y;
         FLD_Z:   v = {3'b000, wd.z};
         default: v = {2'b00, wd.w};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/xyz_fifo.sv
// Input word buffer for the unpacker.
// Occupancy counter decides full/empty; head read is combinational.
module xyz_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push into a full buffer is only taken alongside a pop.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/xyz_unpacker.sv
// Splits packed xyz words into a stream of (id, data, last) fields.
// Current word lives in a register popped from the buffer head.
import xyz_pkg::*;

module xyz_unpacker #(
   parameter int SKIP_ZERO = 0,
   parameter int DEPTH     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XYZ_W-1:0] in_data,
   output logic             field_valid,
   input  logic             field_ready,
   output logic [1:0]       field_id,
   output logic [3:0]       field_data,
   output logic             field_last
);

   typedef enum logic [2:0] {
      IDLE, EMIT_X, EMIT_Y, EMIT_Z, EMIT_W
   } state_e;

   localparam logic SKIP = (SKIP_ZERO != 0);

   state_e           state;
   xyz_t             word;
   xyz_t             head;
   logic [XYZ_W-1:0] head_raw;
   logic             full;
   logic             empty;
   logic             rdy_en;
   logic             push;
   logic             pop;
   logic             xfer;
   field_id_e        nf_load;
   field_id_e        nf_step;

   function automatic state_e to_state(input field_id_e f);
      state_e s;
      unique case (f)
         FLD_X:   s = EMIT_X;
         FLD_Y:   s = EMIT_Y;
         FLD_Z:   s = EMIT_Z;
         default: s = EMIT_W;
      endcase
      return s;
   endfunction

   // rdy_en keeps in_ready low until the first edge after reset.
   assign in_ready = rdy_en && !full;
   assign push     = in_valid && in_ready;
   assign xfer     = field_valid && field_ready;
   assign pop      = !empty &&
                     (state == IDLE || (state == EMIT_W && field_ready));
   assign head     = xyz_t'(head_raw);

   always_comb begin
      nf_load = next_field(head, 2'd0, SKIP);
      nf_step = next_field(word, field_id + 2'd1, SKIP);
   end

   xyz_fifo #(
      .DEPTH (DEPTH),
      .W     (XYZ_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_data),
      .dout  (head_raw),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         word        <= '0;
         rdy_en      <= 1'b0;
         field_valid <= 1'b0;
         field_id    <= '0;
         field_data  <= '0;
         field_last  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (pop) begin
            word        <= head;
            state       <= to_state(nf_load);
            field_valid <= 1'b1;
            field_id    <= nf_load;
            field_data  <= field_val(head, nf_load);
            field_last  <= (nf_load == FLD_W);
         end else if (xfer) begin
            if (state == EMIT_W) begin
               state       <= IDLE;
               field_valid <= 1'b0;
               field_id    <= '0;
               field_data  <= '0;
               field_last  <= 1'b0;
            end else begin
               state       <= to_state(nf_step);
               field_id    <= nf_step;
               field_data  <= field_val(word, nf_step);
               field_last  <= (nf_step == FLD_W);
            end
         end
      end
   end

endmodule

// File: tb/tb_xyz_unpacker.sv
// Directed bench for xyz_unpacker.
// Instance u0: SKIP_ZERO=0 DEPTH=2; instance u1: SKIP_ZERO=1 DEPTH=4.
module tb_xyz_unpacker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       iv0 = 1'b0, ir0, fv0, fr0 = 1'b0, fl0;
   logic [7:0] id0 = '0;
   logic [1:0] fid0;
   logic [3:0] fd0;

   logic       iv1 = 1'b0, ir1, fv1, fr1 = 1'b0, fl1;
   logic [7:0] id1 = '0;
   logic [1:0] fid1;
   logic [3:0] fd1;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   xyz_unpacker #(.SKIP_ZERO(0), .DEPTH(2)) u0 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (iv0),
      .in_ready    (ir0),
      .in_data     (id0),
      .field_valid (fv0),
      .field_ready (fr0),
      .field_id    (fid0),
      .field_data  (fd0),
      .field_last  (fl0)
   );

   xyz_unpacker #(.SKIP_ZERO(1), .DEPTH(4)) u1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (iv1),
      .in_ready    (ir1),
      .in_data     (id1),
      .field_valid (fv1),
      .field_ready (fr1),
      .field_id    (fid1),
      .field_data  (fd1),
      .field_last  (fl1)
   );

   wire [7:0] f0 = {fv0, fid0, fd0, fl0};
   wire [7:0] f1 = {fv1, fid1, fd1, fl1};

   function automatic logic [7:0] mk(input logic [1:0] i,
                                     input logic [3:0] d,
                                     input logic l);
      return {1'b1, i, d, l};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_fields0", f0, 8'h00);
      chk("rst_fields1", f1, 8'h00);
      chk("rst_ready0", {7'd0, ir0}, 8'h00);
      rst = 1'b0;
      #1;
      chk("ready_pre_edge", {7'd0, ir0}, 8'h00);
      tick();
      chk("ready_rise0", {7'd0, ir0}, 8'h01);
      chk("ready_rise1", {7'd0, ir1}, 8'h01);

      // D3 unpacked on consecutive cycles
      fr0 = 1'b1; iv0 = 1'b1; id0 = 8'hD3;
      tick();
      iv0 = 1'b0;
      chk("d3_lat", f0, 8'h00);
      tick(); chk("d3_x", f0, mk(2'd0, 4'h1, 1'b0));
      tick(); chk("d3_y", f0, mk(2'd1, 4'hA, 1'b0));
      tick(); chk("d3_z", f0, mk(2'd2, 4'h0, 1'b0));
      tick(); chk("d3_w", f0, mk(2'd3, 4'h3, 1'b1));
      tick(); chk("d3_idle", f0, 8'h00);

      // stall toggling on 5A: x0 yB z0 w2
      fr0 = 1'b0; iv0 = 1'b1; id0 = 8'h5A;
      tick();
      iv0 = 1'b0;
      tick(); chk("5a_x", f0, mk(2'd0, 4'h0, 1'b0));
      tick(); chk("5a_x_hold", f0, mk(2'd0, 4'h0, 1'b0));
      fr0 = 1'b1; tick(); chk("5a_y", f0, mk(2'd1, 4'hB, 1'b0));
      fr0 = 1'b0; tick(); chk("5a_y_hold", f0, mk(2'd1, 4'hB, 1'b0));
      fr0 = 1'b1; tick(); chk("5a_z", f0, mk(2'd2, 4'h0, 1'b0));
      fr0 = 1'b0; tick(); chk("5a_z_hold", f0, mk(2'd2, 4'h0, 1'b0));
      fr0 = 1'b1; tick(); chk("5a_w", f0, mk(2'd3, 4'h2, 1'b1));
      fr0 = 1'b0; tick(); chk("5a_w_hold", f0, mk(2'd3, 4'h2, 1'b1));
      fr0 = 1'b1; tick(); chk("5a_idle", f0, 8'h00);

      // fill: one word in FSM, two buffered, then drain with no bubbles
      fr0 = 1'b0; iv0 = 1'b1;
      id0 = 8'h11; tick();
      chk("fill_rdy1", {7'd0, ir0}, 8'h01);
      id0 = 8'h22; tick();
      chk("fill_rdy2", {7'd0, ir0}, 8'h01);
      id0 = 8'h33; tick();
      chk("fill_full", {7'd0, ir0}, 8'h00);
      id0 = 8'h44; tick();
      chk("fill_still_full", {7'd0, ir0}, 8'h00);
      iv0 = 1'b0; fr0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("drain_x", f0, mk(2'd0, 4'h0, 1'b0));
         tick();
         chk("drain_y", f0, mk(2'd1, 4'(2 * (i + 1)), 1'b0));
         tick();
         chk("drain_z", f0, mk(2'd2, 4'h0, 1'b0));
         tick();
         chk("drain_w", f0, mk(2'd3, 4'(i + 1), 1'b1));
         tick();
      end
      chk("drain_idle", f0, 8'h00);

      // SKIP_ZERO: 00 then 84
      fr1 = 1'b1; iv1 = 1'b1;
      id1 = 8'h00; tick();
      id1 = 8'h84; tick();
      iv1 = 1'b0;
      chk("sz_00_w", f1, mk(2'd3, 4'h0, 1'b1));
      tick(); chk("sz_84_x", f1, mk(2'd0, 4'h1, 1'b0));
      tick(); chk("sz_84_z", f1, mk(2'd2, 4'h1, 1'b0));
      tick(); chk("sz_84_w", f1, mk(2'd3, 4'h0, 1'b1));
      tick(); chk("sz_idle", f1, 8'h00);

      // reset while emitting Y of FF with 5A buffered
      fr0 = 1'b0; iv0 = 1'b1;
      id0 = 8'hFF; tick();
      id0 = 8'h5A; tick();
      iv0 = 1'b0; fr0 = 1'b1;
      tick(); chk("ff_y", f0, mk(2'd1, 4'hF, 1'b0));
      fr0 = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_fields", f0, 8'h00);
      chk("mid_rst_ready", {7'd0, ir0}, 8'h00);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_fields", f0, 8'h00);
      tick();
      chk("post_rst_ready", {7'd0, ir0}, 8'h01);
      fr0 = 1'b1; iv0 = 1'b1; id0 = 8'h01;
      tick();
      iv0 = 1'b0;
      chk("01_lat", f0, 8'h00);
      tick(); chk("01_x", f0, mk(2'd0, 4'h0, 1'b0));
      tick(); chk("01_y", f0, mk(2'd1, 4'h0, 1'b0));
      tick(); chk("01_z", f0, mk(2'd2, 4'h0, 1'b0));
      tick(); chk("01_w", f0, mk(2'd3, 4'h1, 1'b1));
      tick(); chk("01_idle", f0, 8'h00);
      tick(); chk("01_no_stale", f0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
